// File: rtl/gty_evr_link_ctrl.sv
// gty_evr_link_ctrl: bring-up and supervision sequencer for the single-lane EVR GTY transceiver
//   clk_freerun_in / reset_n_in   : free-running wizard reset clock, async active-low reset
//   gtpowergood_in .. rx_err_in   : async GT status, each passed through SYNC_STAGES flops
//   force_reset_in                : sync software request for a full reset
//   gtwiz_reset_all_out           : wizard reset-all request
//   gtwiz_reset_rx_datapath_out   : wizard RX datapath reset request
//   rxcommaalignen_out            : comma-align enable (M and P)
//   link_up_out                   : link qualified for the event decoder
//   state_out                     : current state encoding
//   link_drop_cnt_out             : exits from LINK_UP, saturating
//   full_reset_cnt_out            : entries to RESET_ALL, saturating
module gty_evr_link_ctrl #(
  parameter int SYNC_STAGES        = 2,
  parameter int RESET_PULSE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES     = 100000,
  parameter int ERR_WINDOW_CYCLES  = 65536,
  parameter int ERR_THRESHOLD      = 8,
  parameter int MAX_RX_RETRIES     = 4
) (
  input  logic        clk_freerun_in,
  input  logic        reset_n_in,
  input  logic        gtpowergood_in,
  input  logic        cplllock_in,
  input  logic        reset_tx_done_in,
  input  logic        reset_rx_done_in,
  input  logic        rx_cdr_stable_in,
  input  logic        rxbyteisaligned_in,
  input  logic        rx_err_in,
  input  logic        force_reset_in,
  output logic        gtwiz_reset_all_out,
  output logic        gtwiz_reset_rx_datapath_out,
  output logic        rxcommaalignen_out,
  output logic        link_up_out,
  output logic [2:0]  state_out,
  output logic [15:0] link_drop_cnt_out,
  output logic [15:0] full_reset_cnt_out
);
  localparam int CMAX = (TIMEOUT_CYCLES > RESET_PULSE_CYCLES) ?
                        ((TIMEOUT_CYCLES > ERR_WINDOW_CYCLES) ? TIMEOUT_CYCLES : ERR_WINDOW_CYCLES) :
                        ((RESET_PULSE_CYCLES > ERR_WINDOW_CYCLES) ? RESET_PULSE_CYCLES : ERR_WINDOW_CYCLES);
  localparam int CW = $clog2(CMAX + 1);
  localparam int EW = $clog2(ERR_THRESHOLD + 1);
  localparam int RW = $clog2(MAX_RX_RETRIES + 1);

  typedef enum logic [2:0] {
    S_POWER_WAIT = 3'd0,
    S_RESET_ALL  = 3'd1,
    S_WAIT_PLL   = 3'd2,
    S_WAIT_RX    = 3'd3,
    S_WAIT_ALIGN = 3'd4,
    S_LINK_UP    = 3'd5,
    S_RX_RESET   = 3'd6
  } state_t;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  assign w_rst_n = r_rst_sync[1];
  always_ff @(posedge clk_freerun_in or negedge reset_n_in)
    if (!reset_n_in) r_rst_sync <= 2'b00;
    else r_rst_sync <= {r_rst_sync[0], 1'b1};

  logic [6:0] w_async, w_s;
  logic [SYNC_STAGES-1:0][6:0] r_sync;
  assign w_async = {rx_err_in, rxbyteisaligned_in, rx_cdr_stable_in, reset_rx_done_in,
                    reset_tx_done_in, cplllock_in, gtpowergood_in};
  assign w_s = r_sync[SYNC_STAGES-1];
  always_ff @(posedge clk_freerun_in or negedge w_rst_n)
    if (!w_rst_n) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], w_async};

  logic w_pgood, w_lock, w_txd, w_rxd, w_cdr, w_aligned, w_err;
  assign {w_err, w_aligned, w_cdr, w_rxd, w_txd, w_lock, w_pgood} = w_s;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [EW-1:0] r_err_cnt;
  logic [RW-1:0] r_retry;
  logic          r_err_d, r_reset_all, r_rx_dp, r_align_en, r_link_up;
  logic [15:0]   r_drop_cnt, r_full_cnt;
  logic          w_restart, w_entry, w_err_rise, w_err_full, w_retry_max, w_tmo, w_pulse_done, w_wrap;

  // r_cnt is shared: pulse width in the reset states, timeout in WAIT_*, error window in LINK_UP.
  assign w_err_rise   = w_err & ~r_err_d;
  assign w_err_full   = r_err_cnt == EW'(ERR_THRESHOLD);
  assign w_retry_max  = r_retry == RW'(MAX_RX_RETRIES);
  assign w_tmo        = r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign w_pulse_done = r_cnt == CW'(RESET_PULSE_CYCLES - 1);
  assign w_wrap       = r_cnt == CW'(ERR_WINDOW_CYCLES - 1);

  always_comb begin
    w_next = r_state;
    w_restart = 1'b0;
    if (!w_pgood) w_next = S_POWER_WAIT;
    else if (force_reset_in && r_state != S_POWER_WAIT) begin
      w_next = S_RESET_ALL;
      w_restart = 1'b1;
    end else if (!w_lock && r_state == S_LINK_UP) w_next = S_RESET_ALL;
    else case (r_state)
      S_POWER_WAIT: w_next = S_RESET_ALL;
      S_RESET_ALL:  w_next = w_pulse_done ? S_WAIT_PLL : S_RESET_ALL;
      S_WAIT_PLL:   w_next = (w_lock && w_txd) ? S_WAIT_RX : w_tmo ? S_RESET_ALL : S_WAIT_PLL;
      S_WAIT_RX:    w_next = (w_rxd && w_cdr) ? S_WAIT_ALIGN : w_tmo ? S_RX_RESET : S_WAIT_RX;
      S_WAIT_ALIGN: w_next = w_aligned ? S_LINK_UP : w_tmo ? S_RX_RESET : S_WAIT_ALIGN;
      S_LINK_UP:    w_next = (!w_aligned || w_err_full) ? S_RX_RESET : S_LINK_UP;
      // An RX reset entered with retries exhausted carries no datapath pulse and escalates.
      S_RX_RESET:   w_next = !r_rx_dp ? S_RESET_ALL : w_pulse_done ? S_WAIT_RX : S_RX_RESET;
      default:      w_next = S_POWER_WAIT;
    endcase
  end
  assign w_entry = (w_next != r_state) || w_restart;

  always_ff @(posedge clk_freerun_in or negedge w_rst_n)
    if (!w_rst_n) begin
      r_state     <= S_POWER_WAIT;
      r_cnt       <= '0;
      r_err_d     <= 1'b0;
      r_err_cnt   <= '0;
      r_retry     <= '0;
      r_reset_all <= 1'b1;
      r_rx_dp     <= 1'b0;
      r_align_en  <= 1'b0;
      r_link_up   <= 1'b0;
      r_drop_cnt  <= '0;
      r_full_cnt  <= '0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= (w_entry || (r_state == S_LINK_UP && w_wrap)) ? '0 : r_cnt + CW'(1);
      r_err_d     <= w_err;
      // An error on the wrap cycle opens the new window with a count of one.
      r_err_cnt   <= w_entry ? '0 : (r_state != S_LINK_UP) ? r_err_cnt :
                     w_wrap ? EW'(w_err_rise) : (w_err_rise && !w_err_full) ? r_err_cnt + EW'(1) : r_err_cnt;
      r_retry     <= !w_entry ? r_retry : (w_next == S_RESET_ALL || w_next == S_LINK_UP) ? '0 :
                     (w_next == S_RX_RESET && !w_retry_max) ? r_retry + RW'(1) : r_retry;
      r_reset_all <= w_next == S_POWER_WAIT || w_next == S_RESET_ALL;
      r_rx_dp     <= w_next == S_RX_RESET && (w_entry ? !w_retry_max : r_rx_dp);
      r_align_en  <= w_next == S_WAIT_ALIGN || w_next == S_LINK_UP;
      r_link_up   <= w_next == S_LINK_UP;
      r_drop_cnt  <= (r_state == S_LINK_UP && w_next != S_LINK_UP && r_drop_cnt != 16'hFFFF) ?
                     r_drop_cnt + 16'd1 : r_drop_cnt;
      r_full_cnt  <= (w_entry && w_next == S_RESET_ALL && r_full_cnt != 16'hFFFF) ?
                     r_full_cnt + 16'd1 : r_full_cnt;
    end

  assign gtwiz_reset_all_out         = r_reset_all;
  assign gtwiz_reset_rx_datapath_out = r_rx_dp;
  assign rxcommaalignen_out          = r_align_en;
  assign link_up_out                 = r_link_up;
  assign state_out                   = r_state;
  assign link_drop_cnt_out           = r_drop_cnt;
  assign full_reset_cnt_out          = r_full_cnt;
endmodule

// File: doc/gty_evr_link_ctrl.md
Name: gty_evr_link_ctrl

Overview:
Bring-up and supervision sequencer for the single-lane EVR GTY transceiver. It runs on the free-running reset clock and drives the wizard's reset-all and RX-datapath reset requests and the comma-align enable. It monitors PLL lock, reset-done, CDR and byte alignment, and recovers the link with escalating resets. It sits beside the transceiver wrapper; its link_up output qualifies the EVR event decoder.

Parameters:
SYNC_STAGES, 2, flops per input synchronizer (min 2)
RESET_PULSE_CYCLES, 16, width of every reset pulse issued
TIMEOUT_CYCLES, 100000, max wait in each WAIT_* state
ERR_WINDOW_CYCLES, 65536, error-rate window length
ERR_THRESHOLD, 8, errors within one window that force an RX reset
MAX_RX_RETRIES, 4, consecutive RX resets before escalating to reset-all

Ports:
clk_freerun_in  in  1  free-running clock, same as wizard gtwiz_reset_clk_freerun
reset_n_in  in  1  asynchronous active-low reset
gtpowergood_in  in  1  async GT status
cplllock_in  in  1  async GT status
reset_tx_done_in  in  1  async GT status
reset_rx_done_in  in  1  async GT status
rx_cdr_stable_in  in  1  async GT status
rxbyteisaligned_in  in  1  async GT status
rx_err_in  in  1  async level; high while the decoder sees disparity or not-in-table errors
force_reset_in  in  1  sync pulse; software request for a full reset
gtwiz_reset_all_out  out  1  to wizard gtwiz_reset_all_in
gtwiz_reset_rx_datapath_out  out  1  to wizard gtwiz_reset_rx_datapath_in
rxcommaalignen_out  out  1  to rxmcommaalignen and rxpcommaalignen
link_up_out  out  1  link qualified
state_out  out  3  current state encoding
link_drop_cnt_out  out  16  exits from LINK_UP, saturating
full_reset_cnt_out  out  16  entries to RESET_ALL, saturating

Behaviour:
- Reset: the async assert of reset_n_in forces the following; release is synchronised to clk_freerun_in.
  - State POWER_WAIT.
  - gtwiz_reset_all_out=1, all other outputs 0.
  - All counters 0.
- Every async input passes through SYNC_STAGES flops; "input" below means the synchronised value.
- rx_err edge detect: a rising edge of the synchronised rx_err counts as one error.
- State encoding: 0 POWER_WAIT, 1 RESET_ALL, 2 WAIT_PLL, 3 WAIT_RX, 4 WAIT_ALIGN, 5 LINK_UP, 6 RX_RESET.
- Priority each cycle, highest first:
  1. gtpowergood=0 -> POWER_WAIT (from any state).
  2. force_reset_in -> RESET_ALL (ignored in POWER_WAIT).
  3. cplllock=0 while in LINK_UP -> RESET_ALL.
  4. The current state's local transition.
- POWER_WAIT: reset_all=1; exit to RESET_ALL on gtpowergood=1.
- RESET_ALL:
  - reset_all=1 for exactly RESET_PULSE_CYCLES cycles, then WAIT_PLL.
  - On entry, full_reset_cnt increments and the rx retry count clears.
- WAIT_PLL: cplllock & reset_tx_done -> WAIT_RX.
- WAIT_RX: reset_rx_done & rx_cdr_stable -> WAIT_ALIGN.
- WAIT_ALIGN: rxcommaalignen=1; rxbyteisaligned=1 -> LINK_UP.
- Timeouts: a timer clears on entry to each WAIT_* state. If the exit condition is not met after TIMEOUT_CYCLES cycles in state:
  - WAIT_PLL -> RESET_ALL.
  - WAIT_RX and WAIT_ALIGN -> RX_RESET.
  - An exit condition met on the timeout cycle wins over the timeout.
- LINK_UP:
  - link_up_out=1 and rxcommaalignen=1.
  - The retry count clears on entry.
  - The window timer free-runs. At ERR_WINDOW_CYCLES-1 it wraps and clears the error count; an error on the wrap cycle counts into the new window, giving value 1.
  - The error count saturates at ERR_THRESHOLD.
  - Exit to RX_RESET when rxbyteisaligned=0 or the error count reaches ERR_THRESHOLD.
  - Every exit from LINK_UP, including priority exits, increments link_drop_cnt.
- RX_RESET:
  - If the retry count is already MAX_RX_RETRIES, go to RESET_ALL immediately with no rx_datapath pulse.
  - Otherwise increment the retry count, assert rx_datapath=1 for RESET_PULSE_CYCLES cycles, then go to WAIT_RX.
- Counters saturate at 0xFFFF.
- Outputs are registered; state-derived outputs change on the same clock edge as state_out.
- link_up_out falls on the clock edge that leaves LINK_UP.
- reset_n_in asserted mid-pulse aborts the pulse immediately.

Test Plan:
- Power-up: gtpowergood rises at cycle 10, all status good by cycle 200 -> reset_all high through POWER_WAIT plus 16 cycles; link_up=1 within SYNC_STAGES+1 cycles of aligned; full_reset_cnt=1.
- Alignment loss: deassert rxbyteisaligned in LINK_UP -> link_up falls; rx_datapath pulses exactly 16 cycles; link_drop_cnt=1; link recovers with full_reset_cnt unchanged.
- Error burst: 8 rx_err pulses within one window -> RX_RESET entered. 7 pulses, then 1 pulse after the window wrap -> no exit.
- Escalation: hold rxbyteisaligned=0 so WAIT_ALIGN times out 5 times -> 4 rx_datapath pulses, then RESET_ALL; full_reset_cnt increments by 1.
- Priority: cplllock drop and rx_err threshold reached in the same cycle -> RESET_ALL. gtpowergood drop during RX_RESET -> POWER_WAIT, rx_datapath=0 next cycle.
- PLL timeout: cplllock held 0 -> RESET_ALL re-entered every 100000+16 cycles; force_reset_in in LINK_UP -> RESET_ALL next cycle.
